// File: rtl/multicycle_control.sv
// Multicycle RV32I control: sequences FETCH/DECODE/EXEC/MEM/WB and drives every datapath select/enable.
// Latency: ALU 4, load 5, store 4, branch 3, jal 3, illegal 2 cycles, plus one per mem_ready-low wait cycle.
// Backpressure: with MEM_HANDSHAKE_EN defined, FETCH/MEM_READ/MEM_WRITE hold until mem_ready; otherwise mem_ready is unused.
module multicycle_control (
  input  logic        clk,
  input  logic        rst,
  input  logic [6:0]  opcode,
  input  logic [2:0]  funct3,
  input  logic        zero,
  input  logic        mem_ready,
  output logic        mem_req,
  output logic        mem_we,
  output logic        sel_adr,
  output logic        pc_we,
  output logic        sel_pc_src,
  output logic        ir_we,
  output logic [1:0]  sel_alu_a,
  output logic [1:0]  sel_alu_b,
  output logic [1:0]  alu_op,
  output logic [1:0]  sel_result,
  output logic        rf_we,
  output logic        illegal,
  output logic [31:0] instret,
  output logic [3:0]  state
);

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADDR  = 4'd2,
    S_MEM_READ  = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_EXEC_R    = 4'd6,
    S_EXEC_I    = 4'd7,
    S_ALU_WB    = 4'd8,
    S_BRANCH    = 4'd9,
    S_JAL       = 4'd10
  } state_t;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_BR    = 7'b1100011;

  // Mux select encodings, named for readability of the state table
  localparam logic [1:0] A_PC     = 2'b00;
  localparam logic [1:0] A_OLDPC  = 2'b01;
  localparam logic [1:0] A_RS1    = 2'b10;
  localparam logic [1:0] B_RS2    = 2'b00;
  localparam logic [1:0] B_IMM    = 2'b01;
  localparam logic [1:0] B_FOUR   = 2'b10;
  localparam logic [1:0] OP_ADD   = 2'b00;
  localparam logic [1:0] OP_SUB   = 2'b01;
  localparam logic [1:0] OP_FUNCT = 2'b10;
  localparam logic [1:0] R_ALUOUT = 2'b00;
  localparam logic [1:0] R_MEM    = 2'b01;
  localparam logic [1:0] R_ALU    = 2'b10;

  // Held in a plain vector so unused codes 11-15 are representable and recoverable
  logic [3:0]  state_q;
  state_t      state_d;
  logic [31:0] instret_q;
  logic        retire;
  logic        mem_rdy;

`ifdef MEM_HANDSHAKE_EN
  assign mem_rdy = mem_ready;
`else
  // Memory is assumed single-cycle; the handshake input is tied off
  logic unused_mem_ready;
  assign unused_mem_ready = mem_ready;
  assign mem_rdy          = 1'b1;
`endif

  // State register; reset and any unused code land in FETCH
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // Retired-instruction counter, wraps naturally at 2^32
  always_ff @(posedge clk) begin
    if (rst) begin
      instret_q <= 32'd0;
    end else if (retire) begin
      instret_q <= instret_q + 32'd1;
    end
  end

  // Next-state and output decode; reset forces every output low so an aborted instruction writes nothing
  always_comb begin
    state_d    = S_FETCH;
    retire     = 1'b0;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    sel_adr    = 1'b0;
    pc_we      = 1'b0;
    sel_pc_src = 1'b0;
    ir_we      = 1'b0;
    sel_alu_a  = A_PC;
    sel_alu_b  = B_RS2;
    alu_op     = OP_ADD;
    sel_result = R_ALUOUT;
    rf_we      = 1'b0;
    illegal    = 1'b0;

    case (state_q)
      S_FETCH: begin
        mem_req   = 1'b1;
        sel_adr   = 1'b0;
        sel_alu_a = A_PC;
        sel_alu_b = B_FOUR;
        alu_op    = OP_ADD;
        if (mem_rdy) begin
          ir_we      = 1'b1;
          pc_we      = 1'b1;
          sel_pc_src = 1'b0;
          state_d    = S_DECODE;
        end else begin
          state_d = S_FETCH;
        end
      end

      S_DECODE: begin
        // Speculatively form the branch/jump target old_pc+imm in alu_out
        sel_alu_a = A_OLDPC;
        sel_alu_b = B_IMM;
        alu_op    = OP_ADD;
        case (opcode)
          OP_R:     state_d = S_EXEC_R;
          OP_I:     state_d = S_EXEC_I;
          OP_LOAD:  state_d = S_MEM_ADDR;
          OP_STORE: state_d = S_MEM_ADDR;
          OP_JAL:   state_d = S_JAL;
          OP_BR: begin
            if (funct3 == 3'b000 || funct3 == 3'b001) begin
              state_d = S_BRANCH;
            end else begin
              illegal = 1'b1;
              state_d = S_FETCH;
            end
          end
          default: begin
            illegal = 1'b1;
            state_d = S_FETCH;
          end
        endcase
      end

      S_MEM_ADDR: begin
        sel_alu_a = A_RS1;
        sel_alu_b = B_IMM;
        alu_op    = OP_ADD;
        state_d   = (opcode == OP_LOAD) ? S_MEM_READ : S_MEM_WRITE;
      end

      S_MEM_READ: begin
        mem_req = 1'b1;
        sel_adr = 1'b1;
        state_d = mem_rdy ? S_MEM_WB : S_MEM_READ;
      end

      S_MEM_WB: begin
        rf_we      = 1'b1;
        sel_result = R_MEM;
        retire     = 1'b1;
        state_d    = S_FETCH;
      end

      S_MEM_WRITE: begin
        mem_req = 1'b1;
        mem_we  = 1'b1;
        sel_adr = 1'b1;
        if (mem_rdy) begin
          retire  = 1'b1;
          state_d = S_FETCH;
        end else begin
          state_d = S_MEM_WRITE;
        end
      end

      S_EXEC_R: begin
        sel_alu_a = A_RS1;
        sel_alu_b = B_RS2;
        alu_op    = OP_FUNCT;
        state_d   = S_ALU_WB;
      end

      S_EXEC_I: begin
        sel_alu_a = A_RS1;
        sel_alu_b = B_IMM;
        alu_op    = OP_FUNCT;
        state_d   = S_ALU_WB;
      end

      S_ALU_WB: begin
        rf_we      = 1'b1;
        sel_result = R_ALUOUT;
        retire     = 1'b1;
        state_d    = S_FETCH;
      end

      S_BRANCH: begin
        // Compare rs1-rs2; target was computed in DECODE and sits in alu_out
        sel_alu_a  = A_RS1;
        sel_alu_b  = B_RS2;
        alu_op     = OP_SUB;
        sel_pc_src = 1'b1;
        pc_we      = (funct3 == 3'b000) ? zero : !zero;
        retire     = 1'b1;
        state_d    = S_FETCH;
      end

      S_JAL: begin
        // ALU forms the link value old_pc+4 while PC loads the target from alu_out
        sel_alu_a  = A_OLDPC;
        sel_alu_b  = B_FOUR;
        sel_result = R_ALU;
        rf_we      = 1'b1;
        pc_we      = 1'b1;
        sel_pc_src = 1'b1;
        retire     = 1'b1;
        state_d    = S_FETCH;
      end

      default: begin
        state_d = S_FETCH;
      end
    endcase

    if (rst) begin
      state_d    = S_FETCH;
      retire     = 1'b0;
      mem_req    = 1'b0;
      mem_we     = 1'b0;
      sel_adr    = 1'b0;
      pc_we      = 1'b0;
      sel_pc_src = 1'b0;
      ir_we      = 1'b0;
      sel_alu_a  = A_PC;
      sel_alu_b  = B_RS2;
      alu_op     = OP_ADD;
      sel_result = R_ALUOUT;
      rf_we      = 1'b0;
      illegal    = 1'b0;
    end
  end

  assign instret = rst ? 32'd0 : instret_q;
  assign state   = rst ? 4'd0  : state_q;

endmodule

// File: tb/tb_multicycle_control.sv
module tb_multicycle_control;

  logic        clk;
  logic        rst;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic        zero;
  logic        mem_ready;
  logic        mem_req;
  logic        mem_we;
  logic        sel_adr;
  logic        pc_we;
  logic        sel_pc_src;
  logic        ir_we;
  logic [1:0]  sel_alu_a;
  logic [1:0]  sel_alu_b;
  logic [1:0]  alu_op;
  logic [1:0]  sel_result;
  logic        rf_we;
  logic        illegal;
  logic [31:0] instret;
  logic [3:0]  state;

  int n_checks = 0;
  int n_fail   = 0;

  int   exp_seq[$];
  logic rdy_seq[$];
  logic exp_br_pc_we;

  multicycle_control dut (
    .clk        (clk),
    .rst        (rst),
    .opcode     (opcode),
    .funct3     (funct3),
    .zero       (zero),
    .mem_ready  (mem_ready),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .sel_adr    (sel_adr),
    .pc_we      (pc_we),
    .sel_pc_src (sel_pc_src),
    .ir_we      (ir_we),
    .sel_alu_a  (sel_alu_a),
    .sel_alu_b  (sel_alu_b),
    .alu_op     (alu_op),
    .sel_result (sel_result),
    .rf_we      (rf_we),
    .illegal    (illegal),
    .instret    (instret),
    .state      (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  // Walk the expected state list, driving mem_ready per step and checking state-specific outputs
  task automatic walk(input string tag);
    for (int i = 0; i < exp_seq.size(); i++) begin
      mem_ready = rdy_seq[i];
      #1;
      check($sformatf("%s state[%0d]", tag, i), {28'd0, state}, exp_seq[i]);
      case (exp_seq[i])
        1: begin
          check({tag, " dec alu_a"}, {30'd0, sel_alu_a}, 32'd1);
          check({tag, " dec alu_b"}, {30'd0, sel_alu_b}, 32'd1);
        end
        3: begin
          check({tag, " rd sel_adr"}, {31'd0, sel_adr}, 32'd1);
          check({tag, " rd mem_req"}, {31'd0, mem_req}, 32'd1);
        end
        4: begin
          check({tag, " mwb rf_we"}, {31'd0, rf_we}, 32'd1);
          check({tag, " mwb sel_res"}, {30'd0, sel_result}, 32'd1);
        end
        5: begin
          check({tag, " wr mem_we"}, {31'd0, mem_we}, 32'd1);
          check({tag, " wr sel_adr"}, {31'd0, sel_adr}, 32'd1);
        end
        6: check({tag, " exr alu_op"}, {30'd0, alu_op}, 32'd2);
        8: begin
          check({tag, " awb rf_we"}, {31'd0, rf_we}, 32'd1);
          check({tag, " awb sel_res"}, {30'd0, sel_result}, 32'd0);
        end
        9: begin
          check({tag, " br pc_we"}, {31'd0, pc_we}, {31'd0, exp_br_pc_we});
          check({tag, " br pc_src"}, {31'd0, sel_pc_src}, 32'd1);
          check({tag, " br alu_op"}, {30'd0, alu_op}, 32'd1);
        end
        10: begin
          check({tag, " jal rf_we"}, {31'd0, rf_we}, 32'd1);
          check({tag, " jal sel_res"}, {30'd0, sel_result}, 32'd2);
          check({tag, " jal pc_we"}, {31'd0, pc_we}, 32'd1);
        end
        default: begin
          if (exp_seq[i] != 0) check({tag, " rf_we idle"}, {31'd0, rf_we}, 32'd0);
        end
      endcase
      if (i < exp_seq.size() - 1) cyc();
    end
  endtask

  task automatic set_seq(input int n, input int s0, input int s1, input int s2,
                         input int s3, input int s4, input int s5, input int s6, input int s7);
    int tmp[8];
    tmp = '{s0, s1, s2, s3, s4, s5, s6, s7};
    exp_seq.delete();
    rdy_seq.delete();
    for (int i = 0; i < n; i++) begin
      exp_seq.push_back(tmp[i]);
      rdy_seq.push_back(1'b1);
    end
  endtask

  initial begin
    rst       = 1'b1;
    opcode    = 7'b0110011;
    funct3    = 3'b000;
    zero      = 1'b0;
    mem_ready = 1'b1;
    exp_br_pc_we = 1'b0;

    // Reset held 3 cycles: every output low
    repeat (3) cyc();
    #1;
    check("rst outputs", {12'd0, mem_req, mem_we, sel_adr, pc_we, sel_pc_src, ir_we,
                          sel_alu_a, sel_alu_b, alu_op, sel_result, rf_we, illegal, state}, 32'd0);
    check("rst instret", instret, 32'd0);

    // Release: FETCH requesting memory
    rst = 1'b0;
    #1;
    check("post-rst state", {28'd0, state}, 32'd0);
    check("post-rst mem_req", {31'd0, mem_req}, 32'd1);
    check("post-rst ir_we", {31'd0, ir_we}, 32'd1);

    // R-type add: 0,1,6,8,0
    set_seq(5, 0, 1, 6, 8, 0, 0, 0, 0);
    walk("rtype");
    check("rtype instret", instret, 32'd1);

    // Load with two mem_ready-low cycles starting at MEM_READ
    opcode = 7'b0000011;
`ifdef MEM_HANDSHAKE_EN
    set_seq(8, 0, 1, 2, 3, 3, 3, 4, 0);
`else
    set_seq(6, 0, 1, 2, 3, 4, 0, 0, 0);
`endif
    rdy_seq[3] = 1'b0;
    rdy_seq[4] = 1'b0;
    walk("load");
    check("load instret", instret, 32'd2);

    // Store: 0,1,2,5,0
    opcode = 7'b0100011;
    set_seq(5, 0, 1, 2, 5, 0, 0, 0, 0);
    walk("store");
    check("store instret", instret, 32'd3);

    // beq taken (zero=1)
    opcode = 7'b1100011; funct3 = 3'b000; zero = 1'b1; exp_br_pc_we = 1'b1;
    set_seq(4, 0, 1, 9, 0, 0, 0, 0, 0);
    walk("beq");
    check("beq instret", instret, 32'd4);

    // bne not taken (zero=1)
    funct3 = 3'b001; exp_br_pc_we = 1'b0;
    walk("bne");
    check("bne instret", instret, 32'd5);

    // JAL
    opcode = 7'b1101111; funct3 = 3'b000; zero = 1'b0;
    set_seq(4, 0, 1, 10, 0, 0, 0, 0, 0);
    walk("jal");
    check("jal instret", instret, 32'd6);

    // Illegal LUI: pulse in DECODE, back to FETCH, no retire
    opcode = 7'b0110111;
    cyc();
    #1;
    check("ill state", {28'd0, state}, 32'd1);
    check("ill pulse", {31'd0, illegal}, 32'd1);
    cyc();
    #1;
    check("ill ret state", {28'd0, state}, 32'd0);
    check("ill pulse end", {31'd0, illegal}, 32'd0);
    check("ill instret", instret, 32'd6);

    // Branch with unsupported funct3 is illegal too
    opcode = 7'b1100011; funct3 = 3'b100;
    cyc();
    #1;
    check("ill br pulse", {31'd0, illegal}, 32'd1);
    cyc();
    #1;
    check("ill br state", {28'd0, state}, 32'd0);

    // Unused state code recovers to FETCH
    force dut.state_q = 4'd12;
    release dut.state_q;
    #1;
    check("code12 state", {28'd0, state}, 32'd12);
    check("code12 mem_req", {31'd0, mem_req}, 32'd0);
    cyc();
    #1;
    check("code12 recover", {28'd0, state}, 32'd0);

    // instret wrap: preload all-ones while in ALU_WB
    opcode = 7'b0010011; funct3 = 3'b000;
    set_seq(4, 0, 1, 7, 8, 0, 0, 0, 0);
    walk("itype");
    force dut.instret_q = 32'hFFFF_FFFF;
    release dut.instret_q;
    #1;
    check("wrap preload", instret, 32'hFFFF_FFFF);
    cyc();
    #1;
    check("wrap state", {28'd0, state}, 32'd0);
    check("wrap instret", instret, 32'd0);

    // Reset asserted in ALU_WB suppresses the write and clears instret
    opcode = 7'b0110011;
    set_seq(4, 0, 1, 6, 8, 0, 0, 0, 0);
    walk("rtype2");
    rst = 1'b1;
    #1;
    check("abort rf_we", {31'd0, rf_we}, 32'd0);
    check("abort state", {28'd0, state}, 32'd0);
    cyc();
    rst = 1'b0;
    #1;
    check("abort instret", instret, 32'd0);
    check("abort fetch", {31'd0, mem_req}, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global watchdog so the run always terminates
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
